keypad_display_ctrl: RTL and testbench
======================================

Name: keypad_display_ctrl

Overview:
- Scans a 4x4 matrix keypad, debounces presses and loads the display digit registers.
- Each accepted key is shifted into the two-digit display: the old s0 moves to s1, and the new key goes to s0.
- s0/s1 drive the existing dual seven-segment multiplexer directly.
- One key press produces exactly one digit update, regardless of how long the key is held.

Parameters:
- SCAN_DIV, 4096: clock cycles each column stays driven; must be >= 4.
- DEBOUNCE_CYCLES, 65536: number of consecutive stable cycles required to accept a press or a release.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rows  input  4  keypad row lines; active-low with pull-ups; asynchronous to clk
- cols  output  4  keypad column drive; one-hot-low pattern
- s0  output  4  most recent key, as a hex nibble
- s1  output  4  previous key, as a hex nibble
- key_valid  output  1  one-cycle pulse in the cycle after s0/s1 update

Behaviour:
- Reset (while reset=0, asynchronous):
  - state=SCAN, col_idx=0, cols=4'b1110
  - s0=0, s1=0, key_valid=0
  - all counters cleared, synchronizer flops = 4'b1111
- Synchronizer: two-flop synchronizer on rows, giving rows_s. All decisions use rows_s only.
- Single press: rows_s has exactly one bit low. Zero or multiple low bits are "no single press".
- Column drive: cols = ~(1 << col_idx).
- Key map by (row, col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- SCAN state:
  - div_cnt counts 0..SCAN_DIV-1.
  - Sample point is div_cnt = SCAN_DIV-1.
  - At the sample point with a single press: capture row index and col_idx, clear deb_cnt, go to DEBOUNCE. col_idx is frozen.
  - At the sample point otherwise: col_idx advances by 1 (mod 4, so 3 wraps to 0) and div_cnt resets.
- DEBOUNCE state:
  - Each cycle with rows_s equal to the captured single-row pattern: deb_cnt++.
  - Any mismatch (release, different row, or multiple rows): return to SCAN and advance col_idx. s0/s1 are unchanged.
  - When deb_cnt reaches DEBOUNCE_CYCLES-1 with a match: s1<=s0, s0<=key. key_valid is high the next cycle for exactly 1 cycle. Go to HELD.
- HELD state:
  - Column stays frozen.
  - While the captured row is low, remain in HELD. Other keys pressed simultaneously are ignored.
  - When the captured row goes high: clear deb_cnt, go to RELEASE.
- RELEASE state:
  - Each cycle with the captured row high: deb_cnt++.
  - If the captured row goes low again: back to HELD with no new key (bounce rejected).
  - When deb_cnt reaches DEBOUNCE_CYCLES-1: go to SCAN, advance col_idx, clear div_cnt.
- Latency: the digit update occurs SCAN_DIV-aligned sample + DEBOUNCE_CYCLES cycles after the synchronized press. The synchronizer adds 2 cycles.
- Reset asserted mid-operation: immediately returns to the reset values listed above. A key still held after reset release is accepted as a new press.
- key_valid never asserts outside the DEBOUNCE→HELD transition.
- cols is never all-high and never has more than one bit low.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_CYCLES=8; the keypad model ties row r low when col c is low and key (r,c) is pressed):
- Reset held low 5 cycles, then released -> cols=1110, s0=0, s1=0, key_valid=0. Idle for 40 cycles -> cols cycles 1110, 1101, 1011, 0111, 1110, each for 4 cycles.
- Press key "5" (r1,c1) for 60 cycles, then release -> exactly one key_valid pulse, s0=5, s1=0. cols stays 1101 throughout the hold.
- Press "A" (r0,c3), release; then press "1" (r0,c0), release -> s0=A, s1=5 after the first press; s0=1, s1=A after the second. Two key_valid pulses total.
- Bouncing press of "F": low 3 cycles, high 2 cycles, then low steady -> no update during the bounce. Exactly one update, s0=F.
- Release bounce while holding "F": high 3 cycles, low 2 cycles, high steady -> no second key_valid, state returns to SCAN. "2" pressed afterwards -> s0=2, s1=F.
- Two keys in the same column pressed together ("4" and "7") -> no key_valid and display unchanged. Assert reset mid-HELD -> s0=s1=0 and cols=1110 immediately.

Source files
------------

// File: rtl/keypad_display_ctrl.sv
// 4x4 matrix keypad scanner with press/release debouncing.
// Each accepted key shifts the two-digit display (s0 -> s1, key -> s0)
// and raises key_valid for one cycle, one cycle after the digit update.
module keypad_display_ctrl #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic       key_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       col_idx;
    logic [1:0]       row_idx;
    logic [3:0]       row_pat;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic             kv_pend;
    logic [3:0]       rows_p0;
    logic [3:0]       rows_p1;
    logic [3:0]       rows_s;

    // True when exactly one row line is pulled low.
    function automatic logic single_low(input logic [3:0] r);
        case (r)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    // Index of the low row line; only meaningful when single_low() holds.
    function automatic logic [1:0] low_index(input logic [3:0] r);
        case (r)
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    // One-hot-low column drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        col_drive = ~(4'b0001 << idx);
    endfunction

    // Hex code printed on the keycap at (row, col).
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;
            4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;
            4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;
            4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;
            4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;
            4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;
            4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hE;
            4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hF;
            default: key_code = 4'hD;
        endcase
    endfunction

    assign rows_s = rows_p1;

    // Two-flop synchronizer: rows are asynchronous to clk; idle level is all-high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_p0 <= 4'b1111;
            rows_p1 <= 4'b1111;
        end else begin
            rows_p0 <= rows;
            rows_p1 <= rows_p0;
        end
    end

    // Scan / debounce / hold / release-debounce state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            cols      <= 4'b1110;
            row_idx   <= 2'd0;
            row_pat   <= 4'b1111;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            s0        <= 4'h0;
            s1        <= 4'h0;
            kv_pend   <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            // key_valid trails the digit update by one cycle
            key_valid <= kv_pend;
            kv_pend   <= 1'b0;
            case (state)
                SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (single_low(rows_s)) begin
                            // freeze the column and start confirming the press
                            row_pat <= rows_s;
                            row_idx <= low_index(rows_s);
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            cols    <= col_drive(col_idx + 2'd1);
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s == row_pat) begin
                        if (deb_cnt == DEB_LAST) begin
                            s1      <= s0;
                            s0      <= key_code(row_idx, col_idx);
                            kv_pend <= 1'b1;
                            state   <= HELD;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        // bounce, release or extra rows: abandon and move on
                        state   <= SCAN;
                        div_cnt <= '0;
                        col_idx <= col_idx + 2'd1;
                        cols    <= col_drive(col_idx + 2'd1);
                    end
                end
                HELD: begin
                    // only the captured row matters; other keys are ignored
                    if (rows_s[row_idx]) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!rows_s[row_idx]) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= SCAN;
                        div_cnt <= '0;
                        col_idx <= col_idx + 2'd1;
                        cols    <= col_drive(col_idx + 2'd1);
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_display_ctrl.sv
// Directed bench for keypad_display_ctrl with a behavioural 4x4 keypad model.
module tb_keypad_display_ctrl;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic        key_valid;
    logic [15:0] pressed = '0;

    int checks   = 0;
    int errors   = 0;
    int kv_count = 0;
    int kv_bad   = 0;
    logic [7:0] h1 = '0;
    logic [7:0] h2 = '0;

    always #5 clk = ~clk;

    keypad_display_ctrl #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .s0        (s0),
        .s1        (s1),
        .key_valid (key_valid)
    );

    // Keypad: row r is pulled low while column c is driven low and key (r,c) is down.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    // Count key_valid cycles; each must come the cycle after a display change.
    always @(negedge clk) begin
        if (key_valid) begin
            kv_count++;
            if (!({s0, s1} == h1 && h1 != h2)) kv_bad++;
        end
        h2 = h1;
        h1 = {s0, s1};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_kv(input string tag, input int target);
        int n = 0;
        while (kv_count < target && n < 100) begin
            tick();
            n++;
        end
        check(tag, kv_count, target);
    endtask

    initial begin
        logic [3:0] exp_c;
        int hold_bad;
        int left_col;
        int n;

        // reset
        reset = 1'b0;
        tick(5);
        check("rst_cols", cols, 4'b1110);
        check("rst_s0", s0, 4'h0);
        check("rst_s1", s1, 4'h0);
        check("rst_kv", key_valid, 1'b0);

        // idle column scan, 4 cycles per column
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            exp_c = ~(4'b0001 << ((i / 4) % 4));
            check("idle_cols", cols, exp_c);
            tick();
        end

        // key "5" held 60 cycles
        pressed[1*4+1] = 1'b1;
        hold_bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (kv_count >= 1 && cols != 4'b1101) hold_bad++;
        end
        check("k5_kv", kv_count, 1);
        check("k5_hold_cols", hold_bad, 0);
        check("k5_s0", s0, 4'h5);
        check("k5_s1", s1, 4'h0);
        pressed = '0;
        tick(25);
        check("k5_one_pulse", kv_count, 1);

        // "A" then "1"
        pressed[0*4+3] = 1'b1;
        wait_kv("kA_kv", 2);
        tick(10);
        pressed = '0;
        tick(25);
        check("kA_s0", s0, 4'hA);
        check("kA_s1", s1, 4'h5);
        pressed[0*4+0] = 1'b1;
        wait_kv("k1_kv", 3);
        tick(10);
        pressed = '0;
        tick(25);
        check("k1_s0", s0, 4'h1);
        check("k1_s1", s1, 4'hA);
        check("k1_total", kv_count, 3);

        // bouncing press of "F", aligned to the start of column 2
        n = 0;
        while (cols != 4'b1011 && n < 40) begin
            tick();
            n++;
        end
        check("sync_col2", cols, 4'b1011);
        pressed[3*4+2] = 1'b1;
        tick(3);
        pressed = '0;
        tick(2);
        pressed[3*4+2] = 1'b1;
        tick(4);
        check("fb_no_kv", kv_count, 3);
        check("fb_s0_hold", s0, 4'h1);
        wait_kv("kF_kv", 4);
        tick(20);
        check("kF_once", kv_count, 4);
        check("kF_s0", s0, 4'hF);
        check("kF_s1", s1, 4'h1);

        // release bounce while holding "F"
        pressed = '0;
        tick(3);
        pressed[3*4+2] = 1'b1;
        tick(2);
        pressed = '0;
        left_col = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cols != 4'b1011) left_col = 1;
        end
        check("rb_no_kv", kv_count, 4);
        check("rb_back_scan", left_col, 1);
        pressed[0*4+1] = 1'b1;
        wait_kv("k2_kv", 5);
        tick(10);
        pressed = '0;
        tick(25);
        check("k2_s0", s0, 4'h2);
        check("k2_s1", s1, 4'hF);

        // "4" and "7" together in column 0
        pressed[1*4+0] = 1'b1;
        pressed[2*4+0] = 1'b1;
        tick(60);
        check("dual_kv", kv_count, 5);
        check("dual_s0", s0, 4'h2);
        check("dual_s1", s1, 4'hF);
        pressed = '0;
        tick(5);

        // reset in the middle of HELD, key kept down across reset
        pressed[0*4+2] = 1'b1;
        wait_kv("k3_kv", 6);
        check("k3_s0", s0, 4'h3);
        check("k3_s1", s1, 4'h2);
        tick(5);
        reset = 1'b0;
        #1;
        check("mrst_s0", s0, 4'h0);
        check("mrst_s1", s1, 4'h0);
        check("mrst_cols", cols, 4'b1110);
        check("mrst_kv", key_valid, 1'b0);
        tick(3);
        reset = 1'b1;
        wait_kv("k3b_kv", 7);
        check("k3b_s0", s0, 4'h3);
        check("k3b_s1", s1, 4'h0);
        pressed = '0;
        tick(25);
        check("final_kv", kv_count, 7);
        check("kv_timing", kv_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
